// File: rtl/wbu.sv
// Write-back stage: selects the write-back value, owns the 32x RW register file, counts retirements, raises timer traps.
// Commits in the acceptance cycle; trap_valid follows a trapping accept by 1 cycle. Optional WBU_BYPASS_EN forwards same-cycle writes to the read ports.
// wb_ready drops while a trap is outstanding and returns the cycle after trap_ack.
module wbu #(
  parameter int RW = 64,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_valid,
  output logic          wb_ready,
  input  logic          IntrEn_i,
  input  logic [1:0]    RegWdata_src_i,
  input  logic          RegWr_i,
  input  logic [IW-1:0] inst_i,
  input  logic [RW-1:0] pc_i,
  input  logic [RW-1:0] ALUres_i,
  input  logic [RW-1:0] dataout_i,
  input  logic [RW-1:0] csr_rdata,
  input  logic          clint_mtip,
  input  logic [4:0]    rs1_addr,
  input  logic [4:0]    rs2_addr,
  output logic [RW-1:0] rs1_data,
  output logic [RW-1:0] rs2_data,
  output logic          trap_valid,
  output logic [RW-1:0] trap_epc,
  output logic [RW-1:0] trap_cause,
  input  logic          trap_ack,
  output logic [63:0]   retire_cnt
);

  localparam logic [RW-1:0] MTIMER_CAUSE = {1'b1, (RW-1)'(7)};

  typedef enum logic {RUN, TRAP} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] regs [32];
  logic [RW-1:0] wb_data;
  logic [4:0]    rd;
  logic          accept;
  logic          reg_we;
  logic          take_trap;

  assign rd        = inst_i[11:7];
  assign wb_ready  = (state == RUN);
  assign accept    = lsu_valid & wb_ready;
  assign reg_we    = accept & RegWr_i & (rd != 5'd0);
  assign take_trap = accept & IntrEn_i & clint_mtip;

  always_comb begin
    wb_data = ALUres_i;
    case (RegWdata_src_i)
      2'b00:   wb_data = ALUres_i;
      2'b01:   wb_data = dataout_i;
      2'b10:   wb_data = pc_i + RW'(4);
      default: wb_data = csr_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (take_trap) state_nxt = TRAP;
      TRAP:    if (trap_ack)  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // trap_valid is the registered state itself, so reset clears it asynchronously.
  assign trap_valid = (state == TRAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      trap_epc   <= '0;
      trap_cause <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) retire_cnt <= retire_cnt + 64'd1;
      if (reg_we) regs[rd] <= wb_data;
      if (take_trap) begin
        trap_epc   <= pc_i + RW'(4);
        trap_cause <= MTIMER_CAUSE;
      end
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
`ifdef WBU_BYPASS_EN
    if (reg_we && rs1_addr == rd) rs1_data = wb_data;
    if (reg_we && rs2_addr == rd) rs2_data = wb_data;
`endif
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: register write-back, retirement counting, trap handshake, async reset, same-cycle bypass.
module tb_wbu;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        wb_ready;
  logic        IntrEn_i;
  logic [1:0]  RegWdata_src_i;
  logic        RegWr_i;
  logic [31:0] inst_i;
  logic [63:0] pc_i;
  logic [63:0] ALUres_i;
  logic [63:0] dataout_i;
  logic [63:0] csr_rdata;
  logic        clint_mtip;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        trap_valid;
  logic [63:0] trap_epc;
  logic [63:0] trap_cause;
  logic        trap_ack;
  logic [63:0] retire_cnt;

  int checks = 0;
  int fails  = 0;
  logic [63:0] exp_cnt;

  localparam logic [63:0] CAUSE = 64'h8000_0000_0000_0007;

  wbu #(.RW(64), .IW(32)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wb_ready(wb_ready),
    .IntrEn_i(IntrEn_i), .RegWdata_src_i(RegWdata_src_i), .RegWr_i(RegWr_i),
    .inst_i(inst_i), .pc_i(pc_i), .ALUres_i(ALUres_i), .dataout_i(dataout_i),
    .csr_rdata(csr_rdata), .clint_mtip(clint_mtip), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_cause(trap_cause),
    .trap_ack(trap_ack), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] src, input logic wr,
                       input logic [4:0] rd, input logic [63:0] pc,
                       input logic [63:0] alu, input logic [63:0] dout,
                       input logic [63:0] csr, input logic ie, input logic mtip);
    lsu_valid      = v;
    RegWdata_src_i = src;
    RegWr_i        = wr;
    inst_i         = {20'h0, rd, 7'h13};
    pc_i           = pc;
    ALUres_i       = alu;
    dataout_i      = dout;
    csr_rdata      = csr;
    IntrEn_i       = ie;
    clint_mtip     = mtip;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 5'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    trap_ack = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      checks++;
      if (rs1_data !== 64'h0 || rs2_data !== 64'h0) begin
        fails++;
        $display("FAIL reset_reg x%0d: got %h/%h want 0", i, rs1_data, rs2_data);
      end
    end
    checks++;
    if (retire_cnt !== 64'h0 || wb_ready !== 1'b1 || trap_valid !== 1'b0 ||
        trap_epc !== 64'h0 || trap_cause !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: cnt=%h rdy=%b tv=%b epc=%h cause=%h want 0/1/0/0/0",
               retire_cnt, wb_ready, trap_valid, trap_epc, trap_cause);
    end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 2'b00, 1'b1, 5'd5, 64'h100, 64'h1234, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    exp_cnt++;
    lsu_valid = 1'b0;
    rs1_addr  = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 64'h1234 || retire_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL alu_write: x5=%h cnt=%0d want 1234/%0d", rs1_data, retire_cnt, exp_cnt);
    end
    drive(1'b1, 2'b00, 1'b1, 5'd0, 64'h100, 64'h1234, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    exp_cnt++;
    lsu_valid = 1'b0;
    rs1_addr  = 5'd0;
    rs2_addr  = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 64'h0 || rs2_data !== 64'h1234 || retire_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL x0_write: x0=%h x5=%h cnt=%0d want 0/1234/%0d", rs1_data, rs2_data, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b01, 1'b1, 5'd1, 64'h0, 64'h0, 64'hDEAD, 64'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b10, 1'b1, 5'd2, 64'h8000_0000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b11, 1'b1, 5'd3, 64'h0, 64'h0, 64'h0, 64'h42, 1'b0, 1'b0);
    step();
    exp_cnt += 3;
    lsu_valid = 1'b0;
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    checks++;
    if (rs1_data !== 64'hDEAD || rs2_data !== 64'h8000_0004) begin
      fails++;
      $display("FAIL b2b_load_pc: x1=%h x2=%h want dead/80000004", rs1_data, rs2_data);
    end
    rs1_addr = 5'd3;
    #1;
    checks++;
    if (rs1_data !== 64'h42 || retire_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL b2b_csr_cnt: x3=%h cnt=%0d want 42/%0d", rs1_data, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_trap();
    // mtip without IntrEn must not trap
    drive(1'b1, 2'b00, 1'b0, 5'd0, 64'h8000_0008, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
    step();
    exp_cnt++;
    checks++;
    if (trap_valid !== 1'b0 || wb_ready !== 1'b1) begin
      fails++;
      $display("FAIL no_intren: tv=%b rdy=%b want 0/1", trap_valid, wb_ready);
    end
    drive(1'b1, 2'b00, 1'b1, 5'd4, 64'h8000_0010, 64'h99, 64'h0, 64'h0, 1'b1, 1'b1);
    step();
    exp_cnt++;
    // a second entry waits while the trap is outstanding
    drive(1'b1, 2'b00, 1'b1, 5'd6, 64'h8000_0014, 64'h77, 64'h0, 64'h0, 1'b0, 1'b0);
    rs1_addr = 5'd4;
    rs2_addr = 5'd6;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (trap_valid !== 1'b1 || trap_epc !== 64'h8000_0014 || trap_cause !== CAUSE ||
          wb_ready !== 1'b0 || retire_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL trap_hold c%0d: tv=%b epc=%h cause=%h rdy=%b cnt=%0d want 1/80000014/%h/0/%0d",
                 c, trap_valid, trap_epc, trap_cause, wb_ready, retire_cnt, CAUSE, exp_cnt);
      end
      step();
    end
    checks++;
    if (rs1_data !== 64'h99 || rs2_data !== 64'h0) begin
      fails++;
      $display("FAIL trap_commit: x4=%h x6=%h want 99/0", rs1_data, rs2_data);
    end
    lsu_valid = 1'b0;
    trap_ack  = 1'b1;
    step();
    trap_ack = 1'b0;
    checks++;
    if (trap_valid !== 1'b0 || wb_ready !== 1'b1 || retire_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL trap_exit: tv=%b rdy=%b cnt=%0d want 0/1/%0d", trap_valid, wb_ready, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b00, 1'b0, 5'd0, 64'h8000_0020, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1);
    step();
    lsu_valid = 1'b0;
    checks++;
    if (trap_valid !== 1'b1) begin
      fails++;
      $display("FAIL trap_enter: tv=%b want 1", trap_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (trap_valid !== 1'b0 || wb_ready !== 1'b1 || retire_cnt !== 64'h0) begin
      fails++;
      $display("FAIL async_reset: tv=%b rdy=%b cnt=%0d want 0/1/0", trap_valid, wb_ready, retire_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt;
    drive(1'b1, 2'b00, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    lsu_valid = 1'b0;
    checks++;
    if (retire_cnt !== 64'h0) begin
      fails++;
      $display("FAIL cnt_wrap: cnt=%h want 0", retire_cnt);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] exp_same;
`ifdef WBU_BYPASS_EN
    exp_same = 64'h55;
`else
    exp_same = 64'h11;
`endif
    drive(1'b1, 2'b00, 1'b1, 5'd7, 64'h0, 64'h11, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b00, 1'b1, 5'd7, 64'h0, 64'h55, 64'h0, 64'h0, 1'b0, 1'b0);
    rs2_addr = 5'd7;
    #1;
    checks++;
    if (rs2_data !== exp_same) begin
      fails++;
      $display("FAIL bypass_same_cycle: x7=%h want %h", rs2_data, exp_same);
    end
    step();
    lsu_valid = 1'b0;
    checks++;
    if (rs2_data !== 64'h55) begin
      fails++;
      $display("FAIL bypass_next_cycle: x7=%h want 55", rs2_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_back_to_back();
    test_trap();
    test_async_reset();
    test_wrap();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wbu.md
# wbu

Write-back stage of the NPC pipeline, directly downstream of the load/store stage. It accepts one retiring instruction per handshake, selects the write-back value and writes the 32-entry integer register file, which it owns. It counts retired instructions and turns a pending timer interrupt into a registered trap request for the fetch/CSR logic. It also supplies the two combinational register read ports used by decode.

## Interface
- RW, default 64: data/register width (matches `RegWidth`).
- IW, default 32: instruction width (matches `INSTWide`).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- lsu_valid  in  1  upstream entry valid.
- wb_ready  out  1  this stage can accept.
- IntrEn_i  in  1  interrupts enabled at this instruction boundary.
- RegWdata_src_i  in  2  write-back source: 00 ALUres, 01 mem dataout, 10 pc+4, 11 csr_rdata.
- RegWr_i  in  1  register write enable.
- inst_i  in  IW  instruction; rd = inst_i[11:7].
- pc_i  in  RW  instruction PC.
- ALUres_i  in  RW  ALU result.
- dataout_i  in  RW  load data.
- csr_rdata  in  RW  CSR read value, sampled with the entry.
- clint_mtip  in  1  timer interrupt pending.
- rs1_addr, rs2_addr  in  5  read addresses.
- rs1_data, rs2_data  out  RW  read data, combinational; x0 always reads 0.
- trap_valid  out  1  interrupt trap request.
- trap_epc  out  RW  return PC (pc of the trapping instruction + 4).
- trap_cause  out  RW  0x8000_0000_0000_0007 (machine timer interrupt).
- trap_ack  in  1  consumer has taken the trap.
- retire_cnt  out  64  retired instruction count.

## Operation
- Accept = lsu_valid & wb_ready. Each accepted entry commits in its acceptance cycle.
- Write-back value by RegWdata_src_i: ALUres_i, dataout_i, pc_i+4 (modulo 2^RW), or csr_rdata.
- Register write occurs at the acceptance edge when RegWr_i=1 and rd≠0. Writes to x0 are dropped.
- retire_cnt increments by 1 per accept and wraps from 2^64-1 to 0.
- FSM has two states, RUN and TRAP.
- RUN: wb_ready=1. On an accept with IntrEn_i & clint_mtip:
  - the instruction still commits normally;
  - next state is TRAP;
  - trap_valid, trap_epc and trap_cause are registered at that edge.
- TRAP: wb_ready=0 and trap_valid=1, with trap_epc and trap_cause held stable.
- TRAP exit: when trap_ack=1, next state is RUN and trap_valid drops at that edge. An accept can occur in the cycle after the trap_ack.
- trap_ack is ignored in RUN.
- clint_mtip is ignored when no accept happens or IntrEn_i=0.

## Timing
- Reset values: FSM=RUN, wb_ready=1, trap_valid=0, trap_epc=0, trap_cause=0, retire_cnt=0. All 32 registers are 0.
- Reset mid-TRAP abandons the trap immediately (asynchronous clear).
- Written data is architecturally visible to a read in the cycle after acceptance, and in the same cycle if WBU_BYPASS_EN is defined.
- Latency from trap-causing accept to trap_valid: 1 cycle. The minimum TRAP dwell is 1 cycle (trap_ack already high).
- Upstream must hold its entry stable while lsu_valid=1 and wb_ready=0.

## Configuration
- WBU_BYPASS_EN defined: during an accept with RegWr_i=1 and rd≠0, a read port whose address equals rd returns the write-back value in the same cycle.
- WBU_BYPASS_EN undefined: read ports return the stored register value only; the new value appears the next cycle.

## Test plan
- Reset, then read all 32 registers → 0. retire_cnt=0, wb_ready=1, trap_valid=0.
- Accept with src=00, ALUres=0x1234, rd=5, RegWr=1 → next cycle rs1_addr=5 reads 0x1234 and retire_cnt=1. The same entry with rd=0 → x0 still reads 0.
- Back-to-back accepts with src=01 (load 0xDEAD), src=10 (pc 0x8000_0000) and src=11 (csr 0x42), each to rd=1..3 → reads return 0xDEAD, 0x8000_0004, 0x42; retire_cnt=3.
- Accept with IntrEn=1, mtip=1, pc=0x8000_0010 → next cycle trap_valid=1, trap_epc=0x8000_0014, trap_cause=0x8000_0000_0000_0007, wb_ready=0. Hold trap_ack=0 for 3 cycles → outputs stable and no accept. Pulse trap_ack → RUN, wb_ready=1.
- Assert rst asynchronously while in TRAP → trap_valid=0 and wb_ready=1 immediately. Preload retire_cnt to 0xFFFF_FFFF_FFFF_FFFF via accepts/force, then accept once → retire_cnt=0.
- Same-cycle write rd=7 and read rs2_addr=7, value 0x55 → rs2_data=0x55 with WBU_BYPASS_EN defined, old value without it.
